// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmitter arbiter: FSM state encoding and
// the default requester-index width.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int ID_W        = $clog2(DEF_NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning
// upward from the index after the previous owner, wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_id_i,
  output logic               found_o,
  output logic [ID_W-1:0]    id_o
);

  logic [ID_W-1:0] idx;

  always_comb begin
    found_o = 1'b0;
    id_o    = last_id_i;
    idx     = '0;
    // k = NUM_REQ lands back on the previous owner, so it wins only when alone.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_id_i) + k) % NUM_REQ);
      if (!found_o && req_i[idx]) begin
        found_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin sharing of one UART transmitter between
// NUM_REQ byte streams, with a mid-packet stall watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic                       cfg_enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       stall_abort,
  output logic [CNT_W-1:0]           bytes_sent
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             last_q, last_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [CNT_W-1:0] bytes_sent_q, bytes_sent_d;

  logic             pick_found;
  logic [GID_W-1:0] pick_id;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (GID_W)
  ) u_pick (
    .req_i     (req_valid),
    .last_id_i (grant_id_q),
    .found_o   (pick_found),
    .id_o      (pick_id)
  );

  assign sel_valid = req_valid[grant_id_q];
  assign sel_last  = req_last[grant_id_q];
  assign sel_data  = req_data[{grant_id_q, 3'b000} +: 8];

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    wdog_d        = wdog_q;
    bytes_sent_d  = bytes_sent_q;
    req_ready     = '0;
    tx_start      = 1'b0;
    stall_abort   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_enable && pick_found && !tx_busy) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          wdog_d        = '0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        // Ready comes from the state alone so a requester never waits on itself.
        req_ready[grant_id_q] = 1'b1;
        if (sel_valid) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          wdog_d    = '0;
          state_d   = START;
        end else if (wdog_q == WD_MAX) begin
          stall_abort   = 1'b1;
          grant_valid_d = 1'b0;
          wdog_d        = '0;
          state_d       = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      START: begin
        tx_start     = 1'b1;
        bytes_sent_d = bytes_sent_q + 1'b1;
        state_d      = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_valid_d = 1'b0;
            state_d       = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner index resets to the top so the first scan starts at requester 0.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q       <= IDLE;
      grant_id_q    <= GID_W'(NUM_REQ - 1);
      grant_valid_q <= 1'b0;
      tx_data_q     <= 8'h00;
      last_q        <= 1'b0;
      wdog_q        <= '0;
      bytes_sent_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      wdog_q        <= wdog_d;
      bytes_sent_q  <= bytes_sent_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign bytes_sent  = bytes_sent_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a UART engine model
// (busy one cycle after start, held ten cycles).
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        grant_valid;
  logic [0:0]  grant_id;
  logic        stall_abort;
  logic [15:0] bytes_sent;

  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [15:0] log_q[$];
  int          busy_cnt = 0;
  int          stall_pulses = 0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  int          fail_cnt = 0;

  uart_tx_arbiter #(
    .NUM_REQ       (2),
    .STALL_TIMEOUT (1024),
    .CNT_W         (16)
  ) dut (
    .clock       (clock),
    .resetb      (resetb),
    .cfg_enable  (cfg_enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .stall_abort (stall_abort),
    .bytes_sent  (bytes_sent)
  );

  always #5 clock = ~clock;

  // UART engine model and transmit log {owner, byte}
  always @(posedge clock) begin
    if (stall_abort) stall_pulses <= stall_pulses + 1;
    if (tx_start) begin
      log_q.push_back({7'd0, grant_id, tx_data});
      tx_busy  <= 1'b1;
      busy_cnt <= 10;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid[0] = (q0.size() != 0);
    req_last[0]  = (q0.size() != 0) ? q0[0][8] : 1'b0;
    req_data[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    req_valid[1] = (q1.size() != 0);
    req_last[1]  = (q1.size() != 0) ? q1[0][8] : 1'b0;
    req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
  endtask

  // Advance one cycle from a negedge to the next, consuming accepted bytes.
  task automatic step();
    logic [1:0] rdy_s;
    rdy_s = req_ready;
    @(posedge clock);
    #1;
    if (rdy_s[0] && req_valid[0]) void'(q0.pop_front());
    if (rdy_s[1] && req_valid[1]) void'(q1.pop_front());
    drive();
    @(negedge clock);
  endtask

  task automatic wait_log(input int n, input int bound, input string tag);
    int k;
    k = 0;
    while (log_q.size() < n && k < bound) begin
      step();
      k++;
    end
    chk(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int k;
    k = 0;
    while ((grant_valid || tx_busy) && k < bound) begin
      step();
      k++;
    end
    chk(tag, {30'd0, grant_valid, tx_busy}, 32'd0);
  endtask

  initial begin
    int lb;
    int n;
    int k;
    int sp0;
    logic [15:0] exp_b[8];

    drive();
    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_start", 32'(tx_start), 32'h0);
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_gvalid", 32'(grant_valid), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h1);
    chk("rst_abort", 32'(stall_abort), 32'h0);
    chk("rst_bytes", 32'(bytes_sent), 32'h0);
    resetb = 1'b1;
    cfg_enable = 1'b1;
    step();
    chk("idle_no_req", 32'(grant_valid), 32'h0);

    // single two-byte packet from requester 0
    lb = log_q.size();
    q0.push_back({1'b0, 8'h3D});
    q0.push_back({1'b1, 8'h0F});
    drive();
    step();
    chk("A_ready", 32'(req_ready), 32'h1);
    chk("A_gid", 32'(grant_id), 32'h0);
    chk("A_gvalid", 32'(grant_valid), 32'h1);
    chk("A_nostart", 32'(tx_start), 32'h0);
    step();
    chk("A_start", 32'(tx_start), 32'h1);
    chk("A_data", 32'(tx_data), 32'h3D);
    chk("A_ready_low", 32'(req_ready), 32'h0);
    step();
    chk("A_cnt1", 32'(bytes_sent), 32'h1);
    chk("A_start_once", 32'(tx_start), 32'h0);
    wait_log(lb + 2, 40, "A_log_timeout");
    k = 0;
    while (tx_busy && k < 20) begin
      step();
      k++;
    end
    chk("A_gv_hold", 32'(grant_valid), 32'h1);
    step();
    chk("A_gv_fall", 32'(grant_valid), 32'h0);
    chk("A_bytes", 32'(bytes_sent), 32'h2);
    chk("A_log0", 32'(log_q[lb]), 32'h003D);
    chk("A_log1", 32'(log_q[lb+1]), 32'h000F);

    // both requesters valid from reset, two packets each
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    lb = log_q.size();
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h12});
    q0.push_back({1'b0, 8'h13}); q0.push_back({1'b1, 8'h14});
    q1.push_back({1'b0, 8'h21}); q1.push_back({1'b1, 8'h22});
    q1.push_back({1'b0, 8'h23}); q1.push_back({1'b1, 8'h24});
    drive();
    wait_log(lb + 8, 300, "B_log_timeout");
    exp_b = '{16'h0011, 16'h0012, 16'h0121, 16'h0122,
              16'h0013, 16'h0014, 16'h0123, 16'h0124};
    for (int i = 0; i < 8; i++)
      chk($sformatf("B_order%0d", i), 32'(log_q[lb+i]), 32'(exp_b[i]));
    wait_idle(40, "B_idle");

    // requester 1 stalls mid-packet; requester 0 waits
    lb = log_q.size();
    sp0 = stall_pulses;
    q1.push_back({1'b0, 8'hAA});
    drive();
    wait_log(lb + 1, 20, "C_log_timeout");
    q0.push_back({1'b1, 8'h55});
    drive();
    k = 0;
    while (req_ready != 2'b10 && k < 40) begin
      step();
      k++;
    end
    n = 1;
    while (!stall_abort && n < 1100) begin
      step();
      n++;
    end
    chk("C_stall_cycle", 32'(n), 32'd1024);
    chk("C_owner_ready", 32'(req_ready), 32'h2);
    step();
    chk("C_pulse_once", 32'(stall_abort), 32'h0);
    chk("C_released", 32'(grant_valid), 32'h0);
    chk("C_pulses", 32'(stall_pulses - sp0), 32'd1);
    step();
    chk("C_next_ready", 32'(req_ready), 32'h1);
    chk("C_next_gid", 32'(grant_id), 32'h0);
    wait_idle(40, "C_idle");
    chk("C_log", 32'(log_q[lb+1]), 32'h0055);
    chk("C_bytes", 32'(bytes_sent), 32'd10);

    // cfg_enable dropped during first byte of a three-byte packet
    lb = log_q.size();
    q0.push_back({1'b0, 8'h01});
    q0.push_back({1'b0, 8'h02});
    q0.push_back({1'b1, 8'h03});
    drive();
    wait_log(lb + 1, 10, "D_log1_timeout");
    cfg_enable = 1'b0;
    wait_log(lb + 3, 80, "D_log3_timeout");
    wait_idle(40, "D_idle");
    chk("D_log2", 32'(log_q[lb+2]), 32'h0003);
    chk("D_bytes", 32'(bytes_sent), 32'd13);
    q0.push_back({1'b1, 8'h04});
    drive();
    repeat (5) step();
    chk("D_no_grant", 32'(grant_valid), 32'h0);
    chk("D_no_ready", 32'(req_ready), 32'h0);
    chk("D_no_send", 32'(log_q.size()), 32'(lb + 3));
    cfg_enable = 1'b1;
    step();
    chk("D_regrant", 32'(grant_valid), 32'h1);
    chk("D_reready", 32'(req_ready), 32'h1);
    wait_idle(40, "D_idle2");

    // async reset while waiting for the frame to finish
    lb = log_q.size();
    q0.push_back({1'b1, 8'h77});
    drive();
    wait_log(lb + 1, 10, "E_log_timeout");
    step();
    step();
    chk("E_pre_gv", 32'(grant_valid), 32'h1);
    #1 resetb = 1'b0;
    #1;
    chk("E_start", 32'(tx_start), 32'h0);
    chk("E_ready", 32'(req_ready), 32'h0);
    chk("E_gv", 32'(grant_valid), 32'h0);
    chk("E_bytes", 32'(bytes_sent), 32'h0);
    chk("E_gid", 32'(grant_id), 32'h1);
    @(negedge clock);
    resetb = 1'b1;
    q1.push_back({1'b1, 8'h99});
    q0.push_back({1'b1, 8'h88});
    drive();
    wait_log(lb + 3, 80, "E_log3_timeout");
    chk("E_first", 32'(log_q[lb+1]), 32'h0088);
    chk("E_second", 32'(log_q[lb+2]), 32'h0199);
    wait_idle(40, "E_idle");
    chk("E_bytes2", 32'(bytes_sent), 32'd2);

    // byte counter wrap
    force dut.bytes_sent_q = 16'hFFFF;
    step();
    release dut.bytes_sent_q;
    lb = log_q.size();
    sp0 = stall_pulses;
    q0.push_back({1'b1, 8'h5A});
    drive();
    wait_log(lb + 1, 10, "F_log_timeout");
    wait_idle(40, "F_idle");
    chk("F_wrap", 32'(bytes_sent), 32'h0);
    chk("F_log", 32'(log_q[lb]), 32'h005A);
    chk("F_no_abort", 32'(stall_pulses - sp0), 32'd0);
    chk("F_gv", 32'(grant_valid), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
